// File: rtl/wca_lime_trx_seq.sv
// wca_lime_trx_seq
// Power-sequencing controller for the Lime baseband interface control byte.
// One sequencer is shared between RX and TX. A round-robin arbiter picks which
// path it serves. Bringing a path up sets its clock enable, then its path
// enable, then its mode. Taking a path down parks the mode, then clears the
// enable, then clears the clock. After each clock or enable change the
// sequencer holds for a programmable settle time.
//
// Ports
//   clock     DSP clock; all logic is on the rising edge
//   reset     asynchronous, active-low; clears all state
//   rx_want   requested RX path state (level)
//   tx_want   requested TX path state (level)
//   rx_mode   RX input mode applied while RX is on
//   tx_mode   TX output mode applied while TX is on
//   ctrl_out  control byte: [1:0] rx mode, [3:2] tx mode, [4] rxen, [5] txen,
//             [6] rxclk en, [7] txclk en
//   rx_ready  RX fully up
//   tx_ready  TX fully up
//   busy      sequencer not idle
//   seq_done  one-cycle pulse when an up or down sequence completes
module wca_lime_trx_seq #(
    parameter int CNT_W      = 8,
    parameter int CLK_SETTLE = 16,
    parameter int EN_SETTLE  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_want,
    input  logic       tx_want,
    input  logic [1:0] rx_mode,
    input  logic [1:0] tx_mode,
    output logic [7:0] ctrl_out,
    output logic       rx_ready,
    output logic       tx_ready,
    output logic       busy,
    output logic       seq_done
);

    typedef enum logic [2:0] {
        IDLE, UP_CLK, UP_EN, UP_MODE, DN_MODE, DN_EN, DN_CLK
    } state_e;

    typedef enum logic {PATH_RX = 1'b0, PATH_TX = 1'b1} path_e;

    // Mode 2'b11 on both paths means RX test pattern and TX zeros. This is
    // the safe state for a path that is down.
    localparam logic [1:0]       PARK_MODE = 2'b11;
    localparam logic [7:0]       CTRL_RST  = 8'h0F;
    localparam logic [CNT_W-1:0] CLK_LOAD  = CNT_W'(CLK_SETTLE - 1);
    localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(EN_SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    function automatic logic [7:0] clk_mask(input path_e p);
        return (p == PATH_TX) ? 8'h80 : 8'h40;
    endfunction

    function automatic logic [7:0] en_mask(input path_e p);
        return (p == PATH_TX) ? 8'h20 : 8'h10;
    endfunction

    // Replace only the selected path's mode field. This leaves the other
    // path's bits untouched.
    function automatic logic [7:0] put_mode(input logic [7:0] c, input path_e p,
                                            input logic [1:0] m);
        logic [7:0] r;
        r = c;
        if (p == PATH_TX) r[3:2] = m;
        else              r[1:0] = m;
        return r;
    endfunction

    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    path_e            sel_q, sel_n;
    path_e            last_q, last_n;
    logic [1:0]       mode_q, mode_n;
    logic [7:0]       ctrl_q, ctrl_n;
    logic             rx_ready_q, rx_ready_n;
    logic             tx_ready_q, tx_ready_n;
    logic             busy_q, busy_n;
    logic             seq_done_q, seq_done_n;

    logic  rx_pend, tx_pend, pick_want;
    path_e pick;

    assign rx_pend = (rx_want != rx_ready_q);
    assign tx_pend = (tx_want != tx_ready_q);

    // On a tie, serve the path that was not served last.
    always_comb begin
        if (rx_pend && tx_pend) pick = (last_q == PATH_TX) ? PATH_RX : PATH_TX;
        else if (tx_pend)       pick = PATH_TX;
        else                    pick = PATH_RX;
        pick_want = (pick == PATH_TX) ? tx_want : rx_want;
    end

    // NOTE: every variable written below gets a default first. A path that
    // forgets to assign one would otherwise infer a latch.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        sel_n      = sel_q;
        last_n     = last_q;
        mode_n     = mode_q;
        ctrl_n     = ctrl_q;
        rx_ready_n = rx_ready_q;
        tx_ready_n = tx_ready_q;
        seq_done_n = 1'b0;

        // Each transition carries the entry action of the state it enters,
        // so ctrl_out changes on the very edge that enters that state.
        unique case (state_q)
            IDLE: begin
                if (rx_pend || tx_pend) begin
                    sel_n  = pick;
                    mode_n = (pick == PATH_TX) ? tx_mode : rx_mode;
                    if (pick_want) begin
                        state_n = UP_CLK;
                        ctrl_n  = ctrl_q | clk_mask(pick);
                        cnt_n   = CLK_LOAD;
                    end else begin
                        state_n = DN_MODE;
                        ctrl_n  = put_mode(ctrl_q, pick, PARK_MODE);
                        if (pick == PATH_TX) tx_ready_n = 1'b0;
                        else                 rx_ready_n = 1'b0;
                    end
                end else begin
                    // A live mode change on a path that is already up needs
                    // no sequencing.
                    if (rx_ready_q && (rx_mode != ctrl_q[1:0])) ctrl_n[1:0] = rx_mode;
                    if (tx_ready_q && (tx_mode != ctrl_q[3:2])) ctrl_n[3:2] = tx_mode;
                end
            end
            UP_CLK: begin
                if (cnt_q == CNT_ZERO) begin
                    state_n = UP_EN;
                    ctrl_n  = ctrl_q | en_mask(sel_q);
                    cnt_n   = EN_LOAD;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            UP_EN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_n    = UP_MODE;
                    ctrl_n     = put_mode(ctrl_q, sel_q, mode_q);
                    seq_done_n = 1'b1;
                    last_n     = sel_q;
                    if (sel_q == PATH_TX) tx_ready_n = 1'b1;
                    else                  rx_ready_n = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            UP_MODE: state_n = IDLE;
            DN_MODE: begin
                state_n = DN_EN;
                ctrl_n  = ctrl_q & ~en_mask(sel_q);
                cnt_n   = EN_LOAD;
            end
            DN_EN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_n = DN_CLK;
                    ctrl_n  = ctrl_q & ~clk_mask(sel_q);
                    cnt_n   = CLK_LOAD;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            DN_CLK: begin
                if (cnt_q == CNT_ZERO) begin
                    state_n    = IDLE;
                    seq_done_n = 1'b1;
                    last_n     = sel_q;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= PATH_RX;
            last_q     <= PATH_TX;
            mode_q     <= '0;
            ctrl_q     <= CTRL_RST;
            rx_ready_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            sel_q      <= sel_n;
            last_q     <= last_n;
            mode_q     <= mode_n;
            ctrl_q     <= ctrl_n;
            rx_ready_q <= rx_ready_n;
            tx_ready_q <= tx_ready_n;
            busy_q     <= busy_n;
            seq_done_q <= seq_done_n;
        end
    end

    assign ctrl_out = ctrl_q;
    assign rx_ready = rx_ready_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign seq_done = seq_done_q;

endmodule

// File: tb/tb_wca_lime_trx_seq.sv
// tb_wca_lime_trx_seq
// Self-checking bench for wca_lime_trx_seq with CLK_SETTLE=16 and EN_SETTLE=64.
// Each test drives stimulus on a falling edge and records the cycle count t at
// that moment. It pushes the expected outputs for absolute cycles t+k into a
// scoreboard queue. The drain task samples the DUT on falling edges and pops
// each entry when its cycle arrives.
module tb_wca_lime_trx_seq;

    logic       clock;
    logic       reset;
    logic       rx_want;
    logic       tx_want;
    logic [1:0] rx_mode;
    logic [1:0] tx_mode;
    logic [7:0] ctrl_out;
    logic       rx_ready;
    logic       tx_ready;
    logic       busy;
    logic       seq_done;

    wca_lime_trx_seq #(
        .CNT_W      (8),
        .CLK_SETTLE (16),
        .EN_SETTLE  (64)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_want  (rx_want),
        .tx_want  (tx_want),
        .rx_mode  (rx_mode),
        .tx_mode  (tx_mode),
        .ctrl_out (ctrl_out),
        .rx_ready (rx_ready),
        .tx_ready (tx_ready),
        .busy     (busy),
        .seq_done (seq_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of rising edges seen so far. It is stable when read on a falling edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] ctrl;
        logic       rxr;
        logic       txr;
        logic       sd;
        logic       bsy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push_exp(input string name, input int c, input logic [7:0] ctl,
                            input logic rr, input logic tr, input logic sd,
                            input logic bz);
        exp_t e;
        e.name = name; e.cyc = c; e.ctrl = ctl;
        e.rxr = rr; e.txr = tr; e.sd = sd; e.bsy = bz;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        exp_t e;
        int   waited;
        waited = 0;
        while (sb_q.size() > 0 && waited < budget) begin
            @(negedge clock);
            waited++;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                if (e.cyc != cyc ||
                    {ctrl_out, rx_ready, tx_ready, seq_done, busy} !==
                    {e.ctrl, e.rxr, e.txr, e.sd, e.bsy}) begin
                    $display("FAIL %s: cyc=%0d ctrl_out=%h rx_ready=%b tx_ready=%b seq_done=%b busy=%b; expected cyc=%0d ctrl_out=%h rx_ready=%b tx_ready=%b seq_done=%b busy=%b",
                             e.name, cyc, ctrl_out, rx_ready, tx_ready, seq_done, busy,
                             e.cyc, e.ctrl, e.rxr, e.txr, e.sd, e.bsy);
                end else begin
                    n_pass++;
                end
            end
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            $display("FAIL %s: cycle budget expired before cyc=%0d, expected ctrl_out=%h",
                     e.name, e.cyc, e.ctrl);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        rx_want = 1'b0;
        tx_want = 1'b0;
        rx_mode = 2'b00;
        tx_mode = 2'b00;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({ctrl_out, rx_ready, tx_ready, seq_done, busy} !== {8'h0F, 4'b0000}) begin
            $display("FAIL reset_values: ctrl_out=%h rx_ready=%b tx_ready=%b seq_done=%b busy=%b; expected 0F 0 0 0 0",
                     ctrl_out, rx_ready, tx_ready, seq_done, busy);
        end else begin
            n_pass++;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({ctrl_out, busy} !== {8'h0F, 1'b0}) begin
            $display("FAIL idle_after_reset: ctrl_out=%h busy=%b; expected 0F 0", ctrl_out, busy);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_rx_up();
        int t;
        rx_want = 1'b1;
        rx_mode = 2'b01;
        t = cyc;
        push_exp("rx_up_clk",      t + 1,  8'h4F, 0, 0, 0, 1);
        push_exp("rx_up_clk_hold", t + 16, 8'h4F, 0, 0, 0, 1);
        push_exp("rx_up_en",       t + 17, 8'h5F, 0, 0, 0, 1);
        push_exp("rx_up_en_hold",  t + 80, 8'h5F, 0, 0, 0, 1);
        push_exp("rx_up_mode",     t + 81, 8'h5D, 1, 0, 1, 1);
        push_exp("rx_up_idle",     t + 82, 8'h5D, 1, 0, 0, 0);
        drain(200);
    endtask

    task automatic test_mode_update();
        int t;
        rx_mode = 2'b10;
        t = cyc;
        push_exp("mode_upd",      t + 1, 8'h5E, 1, 0, 0, 0);
        push_exp("mode_upd_hold", t + 2, 8'h5E, 1, 0, 0, 0);
        drain(20);
    endtask

    task automatic test_rx_down();
        int t;
        rx_want = 1'b0;
        t = cyc;
        push_exp("rx_dn_park",     t + 1,  8'h5F, 0, 0, 0, 1);
        push_exp("rx_dn_en",       t + 2,  8'h4F, 0, 0, 0, 1);
        push_exp("rx_dn_en_hold",  t + 65, 8'h4F, 0, 0, 0, 1);
        push_exp("rx_dn_clk",      t + 66, 8'h0F, 0, 0, 0, 1);
        push_exp("rx_dn_clk_hold", t + 81, 8'h0F, 0, 0, 0, 1);
        push_exp("rx_dn_done",     t + 82, 8'h0F, 0, 0, 1, 0);
        push_exp("rx_dn_idle",     t + 83, 8'h0F, 0, 0, 0, 0);
        drain(200);
    endtask

    task automatic test_both_up();
        int t;
        pulse_reset();
        rx_mode = 2'b01;
        tx_mode = 2'b10;
        rx_want = 1'b1;
        tx_want = 1'b1;
        t = cyc;
        push_exp("both_rx_clk",   t + 1,  8'h4F, 0, 0, 0, 1);
        push_exp("both_rx_en",    t + 17, 8'h5F, 0, 0, 0, 1);
        push_exp("both_rx_mode",  t + 81, 8'h5D, 1, 0, 1, 1);
        push_exp("both_turn",     t + 82, 8'h5D, 1, 0, 0, 0);
        push_exp("both_tx_clk",   t + 83, 8'hDD, 1, 0, 0, 1);
        drain(200);
        // TX mode was latched in IDLE; this mid-sequence change must be ignored.
        tx_mode = 2'b01;
        push_exp("both_tx_en",    t + 99,  8'hFD, 1, 0, 0, 1);
        push_exp("both_tx_mode",  t + 163, 8'hF9, 1, 1, 1, 1);
        push_exp("both_tx_idle",  t + 164, 8'hF9, 1, 1, 0, 0);
        drain(200);
        tx_mode = 2'b10;
    endtask

    task automatic test_both_down();
        int t;
        rx_want = 1'b0;
        tx_want = 1'b0;
        t = cyc;
        push_exp("bdn_rx_park",  t + 1,   8'hFB, 0, 1, 0, 1);
        push_exp("bdn_rx_en",    t + 2,   8'hEB, 0, 1, 0, 1);
        push_exp("bdn_rx_clk",   t + 66,  8'hAB, 0, 1, 0, 1);
        push_exp("bdn_rx_done",  t + 82,  8'hAB, 0, 1, 1, 0);
        push_exp("bdn_tx_park",  t + 83,  8'hAF, 0, 0, 0, 1);
        push_exp("bdn_tx_en",    t + 84,  8'h8F, 0, 0, 0, 1);
        push_exp("bdn_tx_clk",   t + 148, 8'h0F, 0, 0, 0, 1);
        push_exp("bdn_tx_done",  t + 164, 8'h0F, 0, 0, 1, 0);
        push_exp("bdn_final",    t + 165, 8'h0F, 0, 0, 0, 0);
        drain(400);
    endtask

    task automatic test_reset_mid();
        int t;
        rx_mode = 2'b01;
        rx_want = 1'b1;
        t = cyc;
        push_exp("rst_mid_clk", t + 1,  8'h4F, 0, 0, 0, 1);
        push_exp("rst_mid_en",  t + 17, 8'h5F, 0, 0, 0, 1);
        drain(100);
        repeat (5) @(negedge clock);
        // Assert and check between clock edges to show the reset is asynchronous.
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({ctrl_out, rx_ready, tx_ready, seq_done, busy} !== {8'h0F, 4'b0000}) begin
            $display("FAIL async_reset: ctrl_out=%h rx_ready=%b tx_ready=%b seq_done=%b busy=%b; expected 0F 0 0 0 0",
                     ctrl_out, rx_ready, tx_ready, seq_done, busy);
        end else begin
            n_pass++;
        end
        @(negedge clock);
        reset = 1'b1;
        t = cyc;
        push_exp("restart_clk",  t + 1,  8'h4F, 0, 0, 0, 1);
        push_exp("restart_en",   t + 17, 8'h5F, 0, 0, 0, 1);
        push_exp("restart_mode", t + 81, 8'h5D, 1, 0, 1, 1);
        drain(200);
    endtask

    initial begin
        test_reset();
        test_rx_up();
        test_mode_update();
        test_rx_down();
        test_both_up();
        test_both_down();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
